// File: rtl/instr_register_alu.sv
// rtl/instr_register_alu.sv - instruction register file with write-time result stage
//
// Purpose:
//   DEPTH-entry register file. Each entry holds an opcode, two signed operands,
//   a valid bit and, when INSTR_REG_RESULT_EN is defined, the arithmetic result
//   and a divide-by-zero flag computed when the entry is written. Reads are
//   registered with one cycle of latency and marked by a single-cycle rd_valid pulse.
//
// Configuration:
//   INSTR_REG_RESULT_EN - when defined, builds the ALU and the result and
//                         div_zero storage. When undefined, rd_result and
//                         rd_div_zero are tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   load_en        in   write strobe
//   opcode         in   4-bit operation code (instr_register_pkg::opcode_t)
//   operand_a/b    in   OPW-bit signed operands
//   write_pointer  in   AW-bit write address
//   rd_en          in   read request
//   read_pointer   in   AW-bit read address
//   rd_valid       out  one-cycle pulse that marks valid read data
//   rd_hit         out  the entry that was read had been written since reset
//   rd_opcode      out  stored opcode
//   rd_operand_a/b out  stored operands
//   rd_result      out  stored 2*OPW-bit signed result
//   rd_div_zero    out  stored divide-by-zero flag
//   num_valid      out  number of distinct entries written since reset

package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;
endpackage

module instr_register_alu #(
  parameter int DEPTH = 32,
  parameter int OPW   = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [3:0]            opcode,
  input  logic [OPW-1:0]        operand_a,
  input  logic [OPW-1:0]        operand_b,
  input  logic [AW-1:0]         write_pointer,
  input  logic                  rd_en,
  input  logic [AW-1:0]         read_pointer,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [3:0]            rd_opcode,
  output logic [OPW-1:0]        rd_operand_a,
  output logic [OPW-1:0]        rd_operand_b,
  output logic [2*OPW-1:0]      rd_result,
  output logic                  rd_div_zero,
  output logic [AW:0]           num_valid
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  logic [DEPTH-1:0] entry_valid;
  logic [3:0]       mem_opcode [DEPTH];
  logic [OPW-1:0]   mem_a      [DEPTH];
  logic [OPW-1:0]   mem_b      [DEPTH];

  // Valid bits, opcode and operands. The read below samples these arrays
  // before this edge's write lands. A read and a write to the same address
  // in the same cycle are therefore read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_valid <= '0;
      num_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_opcode[i] <= '0;
        mem_a[i]      <= '0;
        mem_b[i]      <= '0;
      end
    end else if (load_en) begin
      entry_valid[write_pointer] <= 1'b1;
      mem_opcode[write_pointer]  <= opcode;
      mem_a[write_pointer]       <= operand_a;
      mem_b[write_pointer]       <= operand_b;
      // Count only first writes. The saturation guard is redundant while
      // the valid bits stay consistent. It keeps the counter bounded anyway.
      if (!entry_valid[write_pointer] && num_valid != FULL_COUNT)
        num_valid <= num_valid + ONE_COUNT;
    end
  end

  // Registered read port. Entries that were never written hold zeros from
  // reset, so they read back with all data 0 and no special casing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_hit       <= 1'b0;
      rd_opcode    <= '0;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit       <= entry_valid[read_pointer];
        rd_opcode    <= mem_opcode[read_pointer];
        rd_operand_a <= mem_a[read_pointer];
        rd_operand_b <= mem_b[read_pointer];
      end
    end
  end

`ifdef INSTR_REG_RESULT_EN
  import instr_register_pkg::*;

  logic signed [2*OPW-1:0] a_ext;
  logic signed [2*OPW-1:0] b_ext;
  logic signed [2*OPW-1:0] alu_result;
  logic                    alu_div_zero;

  logic [2*OPW-1:0] mem_result [DEPTH];
  logic             mem_dz     [DEPTH];

  // The operands are extended to the full result width first. This keeps the
  // product exact. It also means that MIN / -1 fits without overflow.
  assign a_ext = {{OPW{operand_a[OPW-1]}}, operand_a};
  assign b_ext = {{OPW{operand_b[OPW-1]}}, operand_b};

  // Single-cycle ALU. Signed / and % truncate toward zero, so the remainder
  // takes the sign of a.
  always_comb begin
    alu_result   = '0;
    alu_div_zero = 1'b0;
    case (opcode)
      PASSA: alu_result = a_ext;
      PASSB: alu_result = b_ext;
      ADD:   alu_result = a_ext + b_ext;
      SUB:   alu_result = a_ext - b_ext;
      MULT:  alu_result = a_ext * b_ext;
      DIV: begin
        if (b_ext == '0) alu_div_zero = 1'b1;
        else             alu_result   = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) alu_div_zero = 1'b1;
        else             alu_result   = a_ext % b_ext;
      end
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_dz[i]     <= 1'b0;
      end
    end else if (load_en) begin
      mem_result[write_pointer] <= alu_result;
      mem_dz[write_pointer]     <= alu_div_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_result   <= '0;
      rd_div_zero <= 1'b0;
    end else if (rd_en) begin
      rd_result   <= mem_result[read_pointer];
      rd_div_zero <= mem_dz[read_pointer];
    end
  end
`else
  assign rd_result   = '0;
  assign rd_div_zero = 1'b0;
`endif

endmodule
